// File: rtl/cw310_usb_reg_fe.sv
// USB parallel-bus front end for the CW310 register map: synchronizes the host
// strobes into usb_clk and issues exactly one reg_read/reg_write per bus cycle.
module cw310_usb_reg_fe #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSYNC_STAGES  = 2
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic                                 usb_cen_n,
    input  logic                                 usb_rd_n,
    input  logic                                 usb_wr_n,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid,
    output logic                                 bus_err
);

    localparam int SMSB = pSYNC_STAGES - 1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WRITE        = 3'd1,
        ST_READ_ISSUE   = 3'd2,
        ST_READ_CAPTURE = 3'd3,
        ST_HOLD         = 3'd4
    } state_t;

    state_t                    state_r;
    logic [pSYNC_STAGES-1:0]   cen_sync_r;
    logic [pSYNC_STAGES-1:0]   rd_sync_r;
    logic [pSYNC_STAGES-1:0]   wr_sync_r;
    logic [pSYNC_STAGES-1:0]   flush_r;
    logic                      armed_r;
    logic [pADDR_WIDTH-1:0]    addr_r;
    logic [7:0]                din_r;
    logic                      act_rd_s;
    logic                      act_wr_s;
    logic                      release_s;
    logic                      start_wr_s;
    logic                      start_rd_s;
    logic                      start_err_s;

    assign act_rd_s    = ~rd_sync_r[SMSB] & ~cen_sync_r[SMSB];
    assign act_wr_s    = ~wr_sync_r[SMSB] & ~cen_sync_r[SMSB];
    assign release_s   = (rd_sync_r[SMSB] & wr_sync_r[SMSB]) | cen_sync_r[SMSB];
    assign start_wr_s  = armed_r & act_wr_s & ~act_rd_s;
    assign start_rd_s  = armed_r & act_rd_s & ~act_wr_s;
    assign start_err_s = armed_r & act_rd_s & act_wr_s;

    // Strobe synchronizers; idle-high so reset looks like an idle bus.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            cen_sync_r <= {pSYNC_STAGES{1'b1}};
            rd_sync_r  <= {pSYNC_STAGES{1'b1}};
            wr_sync_r  <= {pSYNC_STAGES{1'b1}};
        end else begin
            cen_sync_r <= {cen_sync_r[pSYNC_STAGES-2:0], usb_cen_n};
            rd_sync_r  <= {rd_sync_r[pSYNC_STAGES-2:0], usb_rd_n};
            wr_sync_r  <= {wr_sync_r[pSYNC_STAGES-2:0], usb_wr_n};
        end
    end

    // Arming: after reset the chains hold reset values, so wait until real
    // input has flushed through and both strobes are seen released.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_r <= {pSYNC_STAGES{1'b0}};
            armed_r <= 1'b0;
        end else begin
            flush_r <= {flush_r[pSYNC_STAGES-2:0], 1'b1};
            if (flush_r[SMSB] && rd_sync_r[SMSB] && wr_sync_r[SMSB]) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Per-cycle sample of address and write data, held stable by the host.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= {pADDR_WIDTH{1'b0}};
            din_r  <= 8'h00;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
        end
    end

    // Transaction FSM with all bus/register-side outputs registered.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            reg_address   <= {(pADDR_WIDTH-pBYTECNT_SIZE){1'b0}};
            reg_bytecnt   <= {pBYTECNT_SIZE{1'b0}};
            write_data    <= 8'h00;
            usb_dout      <= 8'h00;
            usb_isout     <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            reg_read  <= 1'b0;
            reg_write <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_wr_s) begin
                        state_r       <= ST_WRITE;
                        reg_address   <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt   <= addr_r[pBYTECNT_SIZE-1:0];
                        write_data    <= din_r;
                        reg_write     <= 1'b1;
                        reg_addrvalid <= 1'b1;
                    end else if (start_rd_s) begin
                        state_r       <= ST_READ_ISSUE;
                        reg_address   <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt   <= addr_r[pBYTECNT_SIZE-1:0];
                        reg_read      <= 1'b1;
                        reg_addrvalid <= 1'b1;
                    end else if (start_err_s) begin
                        state_r       <= ST_HOLD;
                        bus_err       <= 1'b1;
                        reg_addrvalid <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_r <= ST_HOLD;
                end
                ST_READ_ISSUE: begin
                    state_r <= ST_READ_CAPTURE;
                end
                ST_READ_CAPTURE: begin
                    state_r   <= ST_HOLD;
                    usb_dout  <= read_data;
                    usb_isout <= 1'b1;
                end
                ST_HOLD: begin
                    // Waiting for the host to release guarantees one strobe per bus cycle.
                    if (release_s) begin
                        state_r       <= ST_IDLE;
                        reg_addrvalid <= 1'b0;
                        usb_isout     <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    reg_addrvalid <= 1'b0;
                    usb_isout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw310_usb_reg_fe.sv
// Directed bench for cw310_usb_reg_fe: table of bus transactions plus
// hand-written conflict, chip-enable gating and reset-abort sequences.
module tb_cw310_usb_reg_fe;

    logic        usb_clk = 1'b0;
    logic        reset_n;
    logic [20:0] usb_addr;
    logic [7:0]  usb_din;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic        usb_cen_n;
    logic        usb_rd_n;
    logic        usb_wr_n;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic exp_bus_err = 1'b0;

    typedef struct {
        logic        is_read;
        logic [20:0] addr;
        logic [7:0]  din;
        logic [7:0]  rdata;
        int          hold;
        logic [13:0] exp_address;
        logic [6:0]  exp_bytecnt;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[8];

    cw310_usb_reg_fe dut (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_cen_n     (usb_cen_n),
        .usb_rd_n      (usb_rd_n),
        .usb_wr_n      (usb_wr_n),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .read_data     (read_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .bus_err       (bus_err)
    );

    always #5 usb_clk = ~usb_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // One bus transaction; cycle 0 is the cycle the strobe falls.
    task automatic run_txn(input vec_t v);
        int n_wr, n_rd, strobe_cyc, av_err, oe_err, last_valid, oe_last, n_end, entry;
        logic rd_prev;
        logic [7:0] dout_at5;
        n_wr = 0; n_rd = 0; strobe_cyc = -1; av_err = 0; oe_err = 0;
        rd_prev = 1'b0; dout_at5 = 8'h00;
        entry      = v.is_read ? 5 : 4;
        last_valid = (v.hold + 2 > entry) ? v.hold + 2 : entry;
        oe_last    = (v.hold + 2 > 5) ? v.hold + 2 : 5;
        n_end      = last_valid + 4;
        usb_addr = v.addr;
        usb_din  = v.din;
        usb_cen_n = 1'b0;
        if (v.is_read) usb_rd_n = 1'b0;
        else           usb_wr_n = 1'b0;
        for (int k = 0; k <= n_end; k++) begin
            if (k > 0) step();
            if (k == v.hold) begin
                usb_rd_n = 1'b1; usb_wr_n = 1'b1; usb_cen_n = 1'b1;
            end
            // Register block answers the cycle after reg_read; garbage otherwise.
            read_data = rd_prev ? v.rdata : ~v.rdata;
            if (reg_write) begin n_wr++; strobe_cyc = k; end
            if (reg_read)  begin n_rd++; strobe_cyc = k; end
            rd_prev = reg_read;
            if (reg_addrvalid !== (k >= 3 && k <= last_valid)) av_err++;
            if (usb_isout !== (v.is_read && k >= 5 && k <= oe_last)) oe_err++;
            if (k == 5) dout_at5 = usb_dout;
        end
        check("wr_pulses", 32'(n_wr), v.is_read ? 32'd0 : 32'd1);
        check("rd_pulses", 32'(n_rd), v.is_read ? 32'd1 : 32'd0);
        check("strobe_cycle", 32'(strobe_cyc), 32'd3);
        check("addrvalid_profile_errs", 32'(av_err), 32'd0);
        check("isout_profile_errs", 32'(oe_err), 32'd0);
        check("reg_address", 32'(reg_address), 32'(v.exp_address));
        check("reg_bytecnt", 32'(reg_bytecnt), 32'(v.exp_bytecnt));
        check("write_data", 32'(write_data), 32'(v.exp_wdata));
        check("usb_dout_held", 32'(usb_dout), 32'(v.exp_dout));
        if (v.is_read) check("usb_dout_cycle5", 32'(dout_at5), 32'(v.rdata));
        check("bus_err", 32'(bus_err), 32'(exp_bus_err));
    endtask

    initial begin
        int n_wr, n_rd, av_cnt, oe_cnt, sc;
        logic e2, e3, rd_prev;

        //         rd    addr          din    rdata  hold  address   bcnt   wdata  dout
        vecs[0] = '{1'b0, 21'h000203, 8'hA5, 8'h00, 10,  14'h0004, 7'h03, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 21'h000180, 8'hEE, 8'h2E, 10,  14'h0003, 7'h00, 8'hA5, 8'h2E};
        vecs[2] = '{1'b0, 21'h1FFFFF, 8'h5A, 8'h00, 200, 14'h3FFF, 7'h7F, 8'h5A, 8'h2E};
        vecs[3] = '{1'b0, 21'h0ABCDE, 8'h3C, 8'h00, 6,   14'h1579, 7'h5E, 8'h3C, 8'h2E};
        vecs[4] = '{1'b1, 21'h0ABCDE, 8'hEE, 8'hC3, 8,   14'h1579, 7'h5E, 8'h3C, 8'hC3};
        vecs[5] = '{1'b0, 21'h000203, 8'h0F, 8'h00, 2,   14'h0004, 7'h03, 8'h0F, 8'hC3};
        vecs[6] = '{1'b1, 21'h1FFFFF, 8'hEE, 8'h81, 1,   14'h3FFF, 7'h7F, 8'h0F, 8'h81};
        vecs[7] = '{1'b0, 21'h000180, 8'h66, 8'h00, 4,   14'h0003, 7'h00, 8'h66, 8'h81};

        reset_n = 1'b0;
        usb_addr = 21'h000000; usb_din = 8'h00; read_data = 8'h00;
        usb_cen_n = 1'b1; usb_rd_n = 1'b1; usb_wr_n = 1'b1;
        step();
        check("reset_ctl", 32'({usb_dout, usb_isout, reg_read, reg_write, reg_addrvalid, bus_err}), 32'd0);
        check("reset_addr_data", 32'({reg_address, reg_bytecnt, write_data}), 32'd0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("idle_ctl", 32'({usb_isout, reg_read, reg_write, reg_addrvalid, bus_err}), 32'd0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // rd_n and wr_n fall together: error, no strobe, no bus drive.
        usb_addr = 21'h000203; usb_cen_n = 1'b0; usb_rd_n = 1'b0; usb_wr_n = 1'b0;
        n_wr = 0; n_rd = 0; av_cnt = 0; oe_cnt = 0; e2 = 1'b0; e3 = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            if (k == 10) begin usb_rd_n = 1'b1; usb_wr_n = 1'b1; usb_cen_n = 1'b1; end
            if (reg_write) n_wr++;
            if (reg_read) n_rd++;
            if (reg_addrvalid) av_cnt++;
            if (usb_isout) oe_cnt++;
            if (k == 2) e2 = bus_err;
            if (k == 3) e3 = bus_err;
        end
        check("conflict_strobes", 32'(n_wr + n_rd), 32'd0);
        check("conflict_addrvalid", 32'(av_cnt), 32'd0);
        check("conflict_isout", 32'(oe_cnt), 32'd0);
        check("conflict_err_c2", 32'(e2), 32'd0);
        check("conflict_err_c3", 32'(e3), 32'd1);
        exp_bus_err = 1'b1;
        run_txn(vecs[7]);

        // Read held off by cen_n high, issued three cycles after cen_n falls.
        usb_addr = 21'h000203; usb_cen_n = 1'b1; usb_rd_n = 1'b0;
        rd_prev = 1'b0; n_rd = 0; n_wr = 0; sc = -1;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) step();
            if (k == 10) usb_cen_n = 1'b0;
            if (k == 16) begin usb_rd_n = 1'b1; usb_cen_n = 1'b1; end
            read_data = rd_prev ? 8'h77 : 8'h88;
            if (reg_read) begin n_rd++; sc = k; end
            if (reg_write) n_wr++;
            rd_prev = reg_read;
        end
        check("cen_rd_pulses", 32'(n_rd), 32'd1);
        check("cen_wr_pulses", 32'(n_wr), 32'd0);
        check("cen_strobe_cycle", 32'(sc), 32'd13);
        check("cen_usb_dout", 32'(usb_dout), 32'h77);
        check("cen_reg_address", 32'(reg_address), 32'h4);
        check("cen_bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset while the FPGA is driving read data, strobe still held low.
        usb_addr = 21'h000180; usb_cen_n = 1'b0; usb_rd_n = 1'b0;
        rd_prev = 1'b0; read_data = 8'h66;
        for (int k = 1; k <= 6; k++) begin
            step();
            read_data = rd_prev ? 8'h99 : 8'h66;
            rd_prev = reg_read;
        end
        check("pre_reset_isout", 32'(usb_isout), 32'd1);
        check("pre_reset_dout", 32'(usb_dout), 32'h99);
        reset_n = 1'b0;
        #1;
        check("midrst_ctl", 32'({usb_dout, usb_isout, reg_read, reg_write, reg_addrvalid, bus_err}), 32'd0);
        check("midrst_addr_data", 32'({reg_address, reg_bytecnt, write_data}), 32'd0);
        step(); step();
        reset_n = 1'b1;
        exp_bus_err = 1'b0;
        n_rd = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (reg_read) n_rd++;
        end
        check("post_reset_no_strobe", 32'(n_rd), 32'd0);
        usb_rd_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        usb_rd_n = 1'b0;
        n_rd = 0; sc = -1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            if (reg_read) begin n_rd++; sc = k; end
        end
        check("rearm_rd_pulses", 32'(n_rd), 32'd1);
        check("rearm_strobe_cycle", 32'(sc), 32'd3);
        usb_rd_n = 1'b1; usb_cen_n = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check("final_idle", 32'({usb_isout, reg_addrvalid, bus_err}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
